// File: rtl/sccb_write_master_if.sv
// sccb_write_master_if: handshake and SCCB pad bundle between the init sequencer and the write master.
//   master modport (write master side):
//     in  start, id[7:0], addr[7:0], data[7:0], siod_in
//     out busy, done, ack_err, sioc, siod_oe
//   slave modport (sequencer / pad side): the mirror image.
interface sccb_write_master_if;
   logic       start;
   logic [7:0] id;
   logic [7:0] addr;
   logic [7:0] data;
   logic       siod_in;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic       sioc;
   logic       siod_oe;
   modport master (
      input  start, id, addr, data, siod_in,
      output busy, done, ack_err, sioc, siod_oe
   );
   modport slave (
      output start, id, addr, data, siod_in,
      input  busy, done, ack_err, sioc, siod_oe
   );
endinterface

// File: rtl/sccb_write_master.sv
// sccb_write_master: three-phase SCCB register write (START, id, addr, data, STOP) paced by divider tick edges.
//   clk_in  : system clock
//   reset   : asynchronous, active-low
//   tick_in : divider square wave; each edge is one quarter-bit phase
//   bus     : start/id/addr/data/siod_in in, busy/done/ack_err/sioc/siod_oe out
//             (siod_oe=1 pulls SIOD low, 0 releases it to the pull-up)
module sccb_write_master #(
   parameter int SYNC_STAGES = 2,
   parameter bit ACK_CHECK   = 1'b1
) (
   input logic                  clk_in,
   input logic                  reset,
   input logic                  tick_in,
   sccb_write_master_if.master  bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_BITS  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
   logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
   logic                   tick_last_q, tick_last_d;
   logic [2:0]             state_q, state_d;
   logic [1:0]             phase_q, phase_d;
   logic [4:0]             bit_q, bit_d;
   logic [23:0]            shift_q, shift_d;
   logic                   sioc_q, sioc_d;
   logic                   siod_oe_q, siod_oe_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   ack_err_q, ack_err_d;
   logic                   ptick;
   logic                   ninth;

   always_comb begin
      tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], tick_in};
      siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], bus.siod_in};
      tick_last_d = tick_sync_q[SYNC_STAGES-1];
      // any divider edge, rising or falling, is one phase
      ptick       = tick_sync_q[SYNC_STAGES-1] ^ tick_last_q;
      // the ACK slot of each byte sits at bit index 8, 17, 26
      ninth       = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
      state_d     = state_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      sioc_d      = sioc_q;
      siod_oe_d   = siod_oe_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ack_err_d   = ack_err_q;
      case (state_q)
         S_IDLE: begin
            // accept only; the first START phase waits for a later ptick
            if (bus.start) begin
               shift_d   = {bus.id, bus.addr, bus.data};
               busy_d    = 1'b1;
               ack_err_d = 1'b0;
               phase_d   = 2'd0;
               bit_d     = 5'd0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (ptick) begin
               phase_d   = (phase_q == 2'd0) ? 2'd1 : 2'd0;
               siod_oe_d = 1'b1;
               sioc_d    = (phase_q == 2'd0);
               state_d   = (phase_q == 2'd0) ? S_START : S_BITS;
            end
         end
         S_BITS: begin
            if (ptick) begin
               phase_d = phase_q + 2'd1;
               case (phase_q)
                  2'd0: begin
                     sioc_d    = 1'b0;
                     siod_oe_d = ninth ? 1'b0 : ~shift_q[23];
                  end
                  2'd1: sioc_d = 1'b1;
                  2'd2: begin
                     if (ACK_CHECK && ninth)
                        ack_err_d = ack_err_q | siod_sync_q[SYNC_STAGES-1];
                  end
                  default: begin
                     sioc_d  = 1'b0;
                     shift_d = ninth ? shift_q : shift_q << 1;
                     bit_d   = (bit_q == 5'd26) ? 5'd0 : bit_q + 5'd1;
                     state_d = (bit_q == 5'd26) ? S_STOP : S_BITS;
                  end
               endcase
            end
         end
         S_STOP: begin
            if (ptick) begin
               phase_d = phase_q + 2'd1;
               case (phase_q)
                  2'd0: siod_oe_d = 1'b1;
                  2'd1: sioc_d = 1'b1;
                  default: begin
                     siod_oe_d = 1'b0;
                     phase_d   = 2'd0;
                     busy_d    = 1'b0;
                     done_d    = 1'b1;
                     state_d   = S_DONE;
                  end
               endcase
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         tick_sync_q <= '0;
         siod_sync_q <= '0;
         tick_last_q <= 1'b0;
         state_q     <= S_IDLE;
         phase_q     <= 2'd0;
         bit_q       <= 5'd0;
         shift_q     <= 24'd0;
         sioc_q      <= 1'b1;
         siod_oe_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ack_err_q   <= 1'b0;
      end else begin
         tick_sync_q <= tick_sync_d;
         siod_sync_q <= siod_sync_d;
         tick_last_q <= tick_last_d;
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         sioc_q      <= sioc_d;
         siod_oe_q   <= siod_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ack_err_q   <= ack_err_d;
      end
   end

   assign bus.sioc    = sioc_q;
   assign bus.siod_oe = siod_oe_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.ack_err = ack_err_q;
endmodule

// File: tb/tb_sccb_write_master.sv
// tb_sccb_write_master: bus-decoding scoreboard bench for the SCCB write master.
module tb_sccb_write_master;
   localparam int S   = 2;
   localparam int LIM = 2000;

   logic clk_in  = 1'b0;
   logic reset   = 1'b0;
   logic tick_in = 1'b0;
   logic ack_low;
   logic [2:0] nack_mask;
   logic [S:0] sh;
   logic [7:0] exp_q[$];
   int n_run  = 0;
   int n_fail = 0;
   int pcnt   = 0;
   int p0, d0;
   int rises, stops, dones, nb_stop;

   sccb_write_master_if bus_if();

   sccb_write_master #(.SYNC_STAGES(S), .ACK_CHECK(1'b1)) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .tick_in (tick_in),
      .bus     (bus_if)
   );

   // open-drain line: DUT pulls low via siod_oe, slave pulls low for ACK
   assign bus_if.siod_in = ~bus_if.siod_oe & ~ack_low;

   always #5 clk_in = ~clk_in;

   always begin
      repeat (6) @(negedge clk_in);
      tick_in = ~tick_in;
   end

   // phase-tick reference: tick_in delayed through S+1 samples
   always @(posedge clk_in or negedge reset)
      if (!reset) sh <= '0;
      else sh <= {sh[S-1:0], tick_in};

   always @(negedge clk_in)
      if (reset && (sh[S-1] ^ sh[S]) && bus_if.busy) pcnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      logic scl, sda, pscl, psda, in_tx;
      logic [8:0] sr;
      logic [7:0] exp;
      int bc, nb;
      pscl = 1'b1; psda = 1'b1; in_tx = 1'b0; bc = 0; nb = 0; sr = '0;
      ack_low = 1'b0; rises = 0; stops = 0; dones = 0; nb_stop = 0;
      forever begin
         @(negedge clk_in);
         scl = bus_if.sioc;
         sda = bus_if.siod_in;
         if (!reset) begin
            in_tx = 1'b0; bc = 0; ack_low = 1'b0;
         end else begin
            if (scl && pscl && psda && !sda) begin
               in_tx = 1'b1; bc = 0; nb = 0; rises = 0;
            end else if (scl && pscl && !psda && sda && in_tx) begin
               in_tx = 1'b0; stops++; nb_stop = nb;
            end else if (in_tx && scl && !pscl) begin
               sr = {sr[7:0], sda};
               bc++; rises++;
               if (bc == 9) begin
                  exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                  check("byte", sr[8:1], exp);
                  nb++; bc = 0;
               end
            end else if (in_tx && !scl && pscl) begin
               ack_low = (bc == 8) && !nack_mask[nb];
            end
            if (bus_if.done) dones++;
         end
         pscl = scl; psda = sda;
      end
   endtask

   task automatic wait_busy();
      for (int i = 0; i < 20 && !bus_if.busy; i++) @(negedge clk_in);
      check("busy_rise", bus_if.busy, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < LIM && !bus_if.done; i++) @(negedge clk_in);
      check("done_seen", bus_if.done, 1);
   endtask

   task automatic wait_rises(input int n);
      for (int i = 0; i < LIM && rises < n; i++) @(negedge clk_in);
      check("rises_reached", rises >= n, 1);
   endtask

   task automatic begin_write(input logic [7:0] i, input logic [7:0] a, input logic [7:0] d, input logic [2:0] m);
      exp_q.push_back(i); exp_q.push_back(a); exp_q.push_back(d);
      nack_mask = m;
      bus_if.id = i; bus_if.addr = a; bus_if.data = d;
      p0 = pcnt;
      bus_if.start = 1'b1;
      @(negedge clk_in);
      check("busy_1cyc", bus_if.busy, 1);
      bus_if.start = 1'b0;
   endtask

   task automatic finish_write(input logic e_ack);
      wait_done();
      check("ack_err", bus_if.ack_err, e_ack);
      check("ticks", pcnt - p0, 113);
      check("busy_at_done", bus_if.busy, 0);
      @(negedge clk_in);
      check("done_pulse", bus_if.done, 0);
      check("stop_bytes", nb_stop, 3);
      check("q_empty", exp_q.size(), 0);
   endtask

   initial begin
      bus_if.start = 1'b0; bus_if.id = '0; bus_if.addr = '0; bus_if.data = '0;
      nack_mask = '0;
      fork monitor(); join_none
      for (int k = 0; k < 3; k++) begin
         repeat (7) @(negedge clk_in);
         check("rst_sioc", bus_if.sioc, 1);
         check("rst_oe", bus_if.siod_oe, 0);
         check("rst_busy", bus_if.busy, 0);
         check("rst_done", bus_if.done, 0);
         check("rst_ack", bus_if.ack_err, 0);
      end
      reset = 1'b1;
      repeat (20) @(negedge clk_in);
      check("idle_sioc", bus_if.sioc, 1);
      check("idle_busy", bus_if.busy, 0);

      begin_write(8'h42, 8'h12, 8'h80, 3'b000);
      finish_write(1'b0);

      begin_write(8'h42, 8'h3A, 8'h5C, 3'b010);
      finish_write(1'b1);

      d0 = dones;
      begin_write(8'h42, 8'h0C, 8'hA5, 3'b000);
      wait_rises(5);
      bus_if.id = 8'h60; bus_if.start = 1'b1;
      @(negedge clk_in);
      bus_if.start = 1'b0;
      finish_write(1'b0);
      repeat (200) @(negedge clk_in);
      check("one_done", dones - d0, 1);

      begin_write(8'h42, 8'h11, 8'h22, 3'b000);
      wait_rises(13);
      reset = 1'b0;
      #1;
      check("mid_sioc", bus_if.sioc, 1);
      check("mid_oe", bus_if.siod_oe, 0);
      check("mid_busy", bus_if.busy, 0);
      check("mid_done", bus_if.done, 0);
      check("mid_ack", bus_if.ack_err, 0);
      exp_q.delete();
      repeat (10) @(negedge clk_in);
      reset = 1'b1;
      repeat (10) @(negedge clk_in);
      begin_write(8'h42, 8'h6B, 8'h01, 3'b000);
      finish_write(1'b0);

      d0 = dones;
      begin_write(8'h42, 8'h15, 8'h33, 3'b000);
      wait_done();
      check("b2b_ticks_a", pcnt - p0, 113);
      exp_q.push_back(8'h42); exp_q.push_back(8'h16); exp_q.push_back(8'hFF);
      bus_if.addr = 8'h16; bus_if.data = 8'hFF;
      p0 = pcnt;
      bus_if.start = 1'b1;
      @(negedge clk_in);
      wait_busy();
      bus_if.start = 1'b0;
      finish_write(1'b0);
      check("b2b_dones", dones - d0, 2);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/sccb_write_master.md
# sccb_write_master

Three-phase SCCB (I2C-compatible) write master that configures the camera sensor over SIOC/SIOD. It runs in the `clk_in` domain and consumes the square-wave output of the 1 µs clock divider in the camera test path as its bus-timing reference. Every transition of that divider output advances the bus by one quarter-bit phase. The camera init sequencer drives it through a start/busy/done handshake, one register write per transaction.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `tick_in` and `siod_in`. Minimum 2.
- `ACK_CHECK`, default 1: 1 = sample the 9th (don't-care/ACK) bit of each byte into `ack_err`; 0 = `ack_err` held at 0.

Ports:
- `clk_in` input 1: system clock.
- `reset` input 1: asynchronous, active-low.
- `tick_in` input 1: divider clock output. Each rising or falling transition is one phase tick.
- `start` input 1: request a write; sampled only when `busy`=0.
- `id` input 8: device write address, e.g. 0x42.
- `addr` input 8: sub-address (register number).
- `data` input 8: register value.
- `siod_in` input 1: SIOD pad input.
- `busy` output 1: transaction in progress.
- `done` output 1: one-`clk_in` pulse at end of transaction.
- `ack_err` output 1: at least one 9th bit in the last transaction sampled high. Valid while `done`=1; holds until the next accept.
- `sioc` output 1: SCCB clock. Push-pull; idles high.
- `siod_oe` output 1: 1 = drive SIOD pad low; 0 = release (pull-up high).

## Operation
- Phase tick: `tick_in` passes through `SYNC_STAGES` flops, then one more register. `ptick`=1 for one `clk_in` cycle when the last two samples differ.
- Accept: in IDLE with `start`=1, latch `id`/`addr`/`data` into a 24-bit shift register.
  - Set `busy`=1 and clear `ack_err` in the next cycle.
  - `start` while `busy`=1 is ignored.
- States (all advance only on `ptick`):
  - IDLE: `sioc`=1, `siod_oe`=0.
  - START, 2 phases:
    - S0: `siod_oe`=1 (SIOD falls while SIOC high).
    - S1: `sioc`=0.
  - BITS, 27 bits in the order `id`, `addr`, `data`, MSB first. Each byte is 8 data bits plus one 9th bit. Each bit has 4 phases:
    - P0: `sioc`=0; `siod_oe`=~bit for data bits, `siod_oe`=0 for the 9th bit.
    - P1: `sioc`=1.
    - P2: `sioc`=1; for the 9th bit with `ACK_CHECK`=1, `ack_err` |= synchronized `siod_in`.
    - P3: `sioc`=0.
  - STOP, 3 phases:
    - T0: `sioc`=0, `siod_oe`=1.
    - T1: `sioc`=1.
    - T2: `siod_oe`=0.
  - DONE: one `clk_in` cycle with `done`=1 and `busy`=0, then IDLE. Requires no `ptick`.
- Counters:
  - 2-bit phase counter.
  - 5-bit bit counter, 0..26. Bit index mod 9 == 8 identifies the 9th bit.
  - No wrap past 26: bit 26 P3 goes directly to STOP T0.
- ACK sampling does not abort the transaction. All 3 bytes and STOP always complete.
- Reset at any time: immediately IDLE, `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `ack_err`=0, all counters 0. The bus is released mid-transfer; no STOP is generated.

## Timing
- All outputs are registered.
- Reset values: `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `ack_err`=0.
- `ptick` latency: `SYNC_STAGES`+1 `clk_in` cycles after a `tick_in` transition.
- Outputs change in the cycle after `ptick` is high.
- Transaction length: 2 + 108 + 3 = 113 phase ticks from the first `ptick` after accept.
- `busy` rises 1 cycle after accept.
- `done` pulses 1 cycle after the 113th `ptick` is consumed. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle after `done`. The first START phase waits for the next `ptick`.
- Simultaneous `start` and `ptick` while in IDLE: accept only; START S0 waits for the following `ptick`.
- SIOD only changes while `sioc`=0, except in START S0 and STOP T2.
- SIOC high time = 2 phases; data setup = 1 phase before the rising edge.

## Test plan
- Reset default: hold `reset`=0 with `tick_in` toggling → `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `ack_err`=0; no state change.
- Basic write: `id`=0x42, `addr`=0x12, `data`=0x80, `siod_in`=0 during 9th bits → SIOD/SIOC decode to START, 0x42, 0x12, 0x80, STOP. Exactly 113 phase ticks; one `done` pulse; `ack_err`=0.
- NACK: `siod_in`=1 during the 9th bit of the `addr` byte only → `ack_err`=1 at `done`; the `data` byte and STOP are still sent.
- Start while busy: pulse `start` with `id`=0x60 mid-transaction → ignored; the original bytes complete; exactly one `done`.
- Reset mid-byte: assert `reset` at bit 12 P1 → same cycle `sioc`=1, `siod_oe`=0, `busy`=0. A fresh write after release completes normally.
- Back-to-back: assert `start` in the `done` cycle with `data`=0xFF → second transaction accepted; its START S0 aligns to the next `ptick`; two `done` pulses 113 ticks apart (±1 tick).
